// File: rtl/demux_entrada_pkg.sv
// Shared types, widths and helpers for the input demultiplexer in front of the lane FIFOs.
package demux_entrada_pkg;

  localparam int unsigned DATA_W  = 10;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned N_LANES = 4;

  // Upstream word: the destination lane rides in the top bits.
  typedef struct packed {
    logic [LANE_W-1:0]        dest;
    logic [DATA_W-LANE_W-1:0] body;
  } word_t;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } occ_e;

  function automatic lane_t dest_of(input word_t w);
    return w.dest;
  endfunction

endpackage

// File: rtl/demux_entrada_if.sv
// Upstream valid/ready word stream into the demultiplexer.
interface demux_entrada_if;
  import demux_entrada_pkg::*;

  logic  valid_in;
  word_t data_in;
  logic  ready_out;

  modport master (output valid_in, output data_in, input  ready_out);
  modport slave  (input  valid_in, input  data_in, output ready_out);

endinterface

// File: rtl/demux_entrada_skid_buf2.sv
// Two-entry in-order holding buffer; entry 0 is always the head.
module demux_entrada_skid_buf2
  import demux_entrada_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t head,
  output logic  head_valid,
  output logic  ready
);

  occ_e  state_q;
  occ_e  state_d;
  word_t entry1_q;
  logic  ld0_c;
  logic  ld1_c;
  logic  shift_c;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and which entry loads; ready is low in TWO so no push arrives there
  always_comb begin
    state_d = state_q;
    ld0_c   = 1'b0;
    ld1_c   = 1'b0;
    shift_c = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          ld0_c   = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld0_c = 1'b1;
        end else if (push) begin
          state_d = TWO;
          ld1_c   = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          shift_c = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Storage plus registered status flags derived from next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      entry1_q   <= '0;
      head_valid <= 1'b0;
      ready      <= 1'b0;
    end else begin
      if (ld0_c) begin
        head <= din;
      end else if (shift_c) begin
        head <= entry1_q;
      end
      if (ld1_c) begin
        entry1_q <= din;
      end
      head_valid <= (state_d != EMPTY);
      ready      <= (state_d != TWO);
    end
  end

endmodule

// File: rtl/demux_entrada.sv
// Routes an upstream word stream to four lane FIFOs by destination field,
// with almost-full backpressure, in-order head-of-line blocking and per-lane counters.
module demux_entrada
  import demux_entrada_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  demux_entrada_if.slave up,
  input  logic  full0,
  input  logic  full1,
  input  logic  full2,
  input  logic  full3,
  output logic  wr0,
  output logic  wr1,
  output logic  wr2,
  output logic  wr3,
  output word_t data_out0,
  output word_t data_out1,
  output word_t data_out2,
  output word_t data_out3,
  output logic  stall,
  input  lane_t cnt_sel,
  output cnt_t  cnt_out
);

  logic [N_LANES-1:0] full_c;
  logic [N_LANES-1:0] wr_q;
  word_t              dout_q [N_LANES];
  cnt_t               cnt_q  [N_LANES];
  word_t              head;
  logic               head_valid;
  logic               ready;
  lane_t              head_dest_c;
  logic               push_c;
  logic               pop_c;

  assign full_c      = {full3, full2, full1, full0};
  assign head_dest_c = dest_of(head);
  assign push_c      = up.valid_in & ready;
  // Full is sampled live; the one-slot margin covers the registered strobe
  assign pop_c       = head_valid & ~full_c[head_dest_c];
  assign up.ready_out = ready;

  demux_entrada_skid_buf2 u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .pop        (pop_c),
    .din        (up.data_in),
    .head       (head),
    .head_valid (head_valid),
    .ready      (ready)
  );

  // Dispatch strobes, lane data, counters and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      stall   <= 1'b0;
      cnt_out <= '0;
      for (int i = 0; i < int'(N_LANES); i++) begin
        dout_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_q    <= '0;
      stall   <= head_valid & full_c[head_dest_c];
      cnt_out <= cnt_q[cnt_sel];
      if (pop_c) begin
        wr_q[head_dest_c]   <= 1'b1;
        dout_q[head_dest_c] <= head;
        cnt_q[head_dest_c]  <= cnt_q[head_dest_c] + CNT_W'(1);
      end
    end
  end

  assign wr0       = wr_q[0];
  assign wr1       = wr_q[1];
  assign wr2       = wr_q[2];
  assign wr3       = wr_q[3];
  assign data_out0 = dout_q[0];
  assign data_out1 = dout_q[1];
  assign data_out2 = dout_q[2];
  assign data_out3 = dout_q[3];

endmodule

// File: tb/tb_demux_entrada.sv
// Bench for demux_entrada: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_demux_entrada;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] full_v = 4'b0000;
  logic [3:0] wr_v;
  logic [9:0] dout [4];
  logic       stall;
  logic [1:0] cnt_sel = 2'd0;
  logic [7:0] cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  demux_entrada_if up_if ();

  demux_entrada dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up_if),
    .full0     (full_v[0]),
    .full1     (full_v[1]),
    .full2     (full_v[2]),
    .full3     (full_v[3]),
    .wr0       (wr_v[0]),
    .wr1       (wr_v[1]),
    .wr2       (wr_v[2]),
    .wr3       (wr_v[3]),
    .data_out0 (dout[0]),
    .data_out1 (dout[1]),
    .data_out2 (dout[2]),
    .data_out3 (dout[3]),
    .stall     (stall),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue of at most two, popped when its head's lane is not full
  logic [9:0] m_q[$];
  logic       m_ready = 1'b0;
  logic       m_stall = 1'b0;
  logic [3:0] m_wr = 4'b0;
  logic [9:0] m_dout [4] = '{default: 10'h0};
  logic [7:0] m_cnt  [4] = '{default: 8'h0};
  logic [7:0] m_cnt_out = 8'h0;

  always @(posedge clk or negedge rst_n) begin
    logic       push;
    logic       pop;
    logic [9:0] w;
    logic [9:0] hd;
    int         d;
    if (!rst_n) begin
      m_q.delete();
      m_ready   = 1'b0;
      m_stall   = 1'b0;
      m_wr      = 4'b0;
      m_cnt_out = 8'h0;
      for (int i = 0; i < 4; i++) begin
        m_dout[i] = 10'h0;
        m_cnt[i]  = 8'h0;
      end
    end else begin
      push = up_if.valid_in && m_ready;
      pop  = 1'b0;
      m_stall = 1'b0;
      if (m_q.size() > 0) begin
        hd = m_q[0];
        d  = int'(hd[9:8]);
        pop     = !full_v[d];
        m_stall = full_v[d];
      end
      m_cnt_out = m_cnt[cnt_sel];
      m_wr = 4'b0;
      if (pop) begin
        w = m_q.pop_front();
        d = int'(w[9:8]);
        m_wr[d]   = 1'b1;
        m_dout[d] = w;
        m_cnt[d]  = m_cnt[d] + 8'd1;
      end
      if (push) m_q.push_back(up_if.data_in);
      m_ready = (m_q.size() < 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("ready", 32'(up_if.ready_out), 32'(m_ready));
    chk("stall", 32'(stall), 32'(m_stall));
    chk("wr", 32'(wr_v), 32'(m_wr));
    for (int i = 0; i < 4; i++) chk($sformatf("data_out%0d", i), 32'(dout[i]), 32'(m_dout[i]));
    chk("cnt_out", 32'(cnt_out), 32'(m_cnt_out));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] w;
    logic [7:0] exp_cnt [4];
    up_if.valid_in = 1'b0;
    up_if.data_in  = '0;
    #1 rst_n = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(up_if.ready_out), 32'd0);
    chk("rst_wr", 32'(wr_v), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt_out", 32'(cnt_out), 32'd0);
    chk("rst_dout2", 32'(dout[2]), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(up_if.ready_out), 32'd1);
    chk("stall_after_rst", 32'(stall), 32'd0);

    // Single word to lane 2
    up_if.valid_in = 1'b1;
    up_if.data_in  = 10'h2A5;
    cnt_sel = 2'd2;
    step();
    up_if.valid_in = 1'b0;
    chk("single_wr_early", 32'(wr_v), 32'd0);
    step();
    chk("single_wr", 32'(wr_v), 32'b0100);
    chk("single_dout2", 32'(dout[2]), 32'h2A5);
    step();
    chk("single_wr_off", 32'(wr_v), 32'd0);
    chk("single_cnt", 32'(cnt_out), 32'd1);
    chk("model_cnt2", 32'(m_cnt[2]), 32'd1);

    // Streaming one word per lane
    up_if.valid_in = 1'b1;
    up_if.data_in = 10'h001; step();
    up_if.data_in = 10'h102; step();
    chk("stream_wr0", 32'(wr_v), 32'b0001);
    up_if.data_in = 10'h203; step();
    chk("stream_wr1", 32'(wr_v), 32'b0010);
    chk("stream_dout0", 32'(dout[0]), 32'h001);
    up_if.data_in = 10'h304; step();
    chk("stream_wr2", 32'(wr_v), 32'b0100);
    chk("stream_ready", 32'(up_if.ready_out), 32'd1);
    up_if.valid_in = 1'b0;
    step();
    chk("stream_wr3", 32'(wr_v), 32'b1000);
    chk("stream_dout3", 32'(dout[3]), 32'h304);
    step();
    step();

    // Backpressure with head-of-line blocking
    full_v = 4'b0010;
    up_if.valid_in = 1'b1;
    up_if.data_in = 10'h111; step();
    up_if.data_in = 10'h022; step();
    up_if.data_in = 10'h033; step();
    chk("bp_stall", 32'(stall), 32'd1);
    chk("bp_ready", 32'(up_if.ready_out), 32'd0);
    chk("bp_wr_blocked", 32'(wr_v), 32'd0);
    full_v = 4'b0000;
    step();
    chk("bp_wr1", 32'(wr_v), 32'b0010);
    chk("bp_dout1", 32'(dout[1]), 32'h111);
    chk("bp_stall_drop", 32'(stall), 32'd0);
    step();
    up_if.valid_in = 1'b0;
    chk("bp_wr0a", 32'(wr_v), 32'b0001);
    chk("bp_dout0a", 32'(dout[0]), 32'h022);
    chk("bp_ready_back", 32'(up_if.ready_out), 32'd1);
    step();
    chk("bp_wr0b", 32'(wr_v), 32'b0001);
    chk("bp_dout0b", 32'(dout[0]), 32'h033);
    step();
    chk("bp_idle", 32'(wr_v), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      up_if.valid_in = ($urandom_range(0, 3) != 0);
      up_if.data_in  = 10'($urandom);
      if ($urandom_range(0, 3) == 0) full_v = 4'($urandom) & 4'($urandom);
      cnt_sel = 2'($urandom);
      step();
    end
    up_if.valid_in = 1'b0;
    full_v = 4'b0000;
    repeat (4) step();

    // Asynchronous reset while two words are held
    full_v = 4'b1000;
    up_if.valid_in = 1'b1;
    up_if.data_in = 10'h3A1; step();
    up_if.data_in = 10'h3B2; step();
    up_if.valid_in = 1'b0;
    step();
    chk("pre_rst_ready", 32'(up_if.ready_out), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wr", 32'(wr_v), 32'd0);
    chk("midrst_ready", 32'(up_if.ready_out), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    step();
    rst_n = 1'b1;
    full_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      step();
      chk("post_rst_no_wr", 32'(wr_v), 32'd0);
      step();
      chk("post_rst_cnt", 32'(cnt_out), 32'd0);
    end

    // Counter wrap on lane 3
    up_if.valid_in = 1'b1;
    for (int i = 0; i < 257; i++) begin
      w = {2'b11, 8'($urandom)};
      up_if.data_in = w;
      step();
    end
    up_if.valid_in = 1'b0;
    repeat (3) step();
    exp_cnt = '{8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      step();
      step();
      chk($sformatf("wrap_cnt%0d", i), 32'(cnt_out), 32'(exp_cnt[i]));
    end
    chk("model_cnt3_wrap", 32'(m_cnt[3]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
